// File: rtl/bldc_pkg.sv
// bldc_pkg: shared widths, hall code constants, commutation successors and FSM states
package bldc_pkg;
  localparam int VEL_W   = 9;
  localparam int VEL_MAX = 255;
  localparam int HALL_W  = 3;
  localparam logic [HALL_W-1:0] HALL_000 = 3'b000;
  localparam logic [HALL_W-1:0] HALL_111 = 3'b111;
  typedef enum logic {INIT, RUN} state_t;
  // Forward commutation order is 1->3->2->6->4->5->1
  function automatic logic [HALL_W-1:0] hall_next(input logic [HALL_W-1:0] c);
    case (c)
      3'd1: return 3'd3;
      3'd3: return 3'd2;
      3'd2: return 3'd6;
      3'd6: return 3'd4;
      3'd4: return 3'd5;
      3'd5: return 3'd1;
      default: return c;
    endcase
  endfunction
  function automatic logic [HALL_W-1:0] hall_prev(input logic [HALL_W-1:0] c);
    case (c)
      3'd1: return 3'd5;
      3'd5: return 3'd4;
      3'd4: return 3'd6;
      3'd6: return 3'd2;
      3'd2: return 3'd3;
      3'd3: return 3'd1;
      default: return c;
    endcase
  endfunction
endpackage

// File: rtl/hall_debounce.sv
// hall_debounce: synchronises the 3 hall lines and accepts a code once stable.
// Ports: clk, rst_n (async active-low), i_hall raw sensors,
//        o_accepted_code last accepted code, o_accept_pulse one cycle per new acceptance.
module hall_debounce
  import bldc_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [HALL_W-1:0] i_hall,
  output logic [HALL_W-1:0] o_accepted_code,
  output logic              o_accept_pulse
);
  localparam int CNTW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNTW-1:0] DMAX = CNTW'(DEBOUNCE_CYCLES);
  logic [SYNC_STAGES-1:0][HALL_W-1:0] r_sync;
  logic [HALL_W-1:0] r_prev, w_s;
  logic [CNTW-1:0] r_cnt, w_cnt_n;
  logic w_accept;
  assign w_s = r_sync[SYNC_STAGES-1];
  // Counts how many consecutive cycles the synced code has held, saturating at DMAX
  assign w_cnt_n = (w_s != r_prev) ? CNTW'(1) : (r_cnt == DMAX) ? DMAX : r_cnt + 1'b1;
  // Re-accepting the current code would be a spurious event, so only changes fire
  assign w_accept = (w_cnt_n == DMAX) && (w_s != o_accepted_code);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync          <= '0;
      r_prev          <= '0;
      r_cnt           <= '0;
      o_accepted_code <= '0;
      o_accept_pulse  <= 1'b0;
    end else begin
      r_sync         <= {r_sync[SYNC_STAGES-2:0], i_hall};
      r_prev         <= w_s;
      r_cnt          <= w_cnt_n;
      o_accept_pulse <= w_accept;
      if (w_accept) o_accepted_code <= w_s;
    end
  end
endmodule

// File: rtl/hall_velocity_meter.sv
// hall_velocity_meter: decodes hall steps and publishes a signed step count per window.
// Ports: clk, rst_n (async active-low), i_hall raw sensors {C,B,A},
//        o_current_vel signed steps per window, o_vel_valid one-cycle update strobe,
//        o_dir last step direction (1 = forward), o_hall_fault fault seen in published window.
// Build option: define VEL_AVG_EN to publish the average of the last two window counts.
module hall_velocity_meter
  import bldc_pkg::*;
#(
  parameter int WINDOW_CYCLES   = 50000,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [HALL_W-1:0]       i_hall,
  output logic signed [VEL_W-1:0] o_current_vel,
  output logic                    o_vel_valid,
  output logic                    o_dir,
  output logic                    o_hall_fault
);
  localparam int CW = $clog2(WINDOW_CYCLES);
  localparam logic signed [VEL_W-1:0] VMAX = VEL_W'(VEL_MAX);
  localparam logic signed [VEL_W-1:0] VMIN = -VMAX;
  logic [CW-1:0] r_win;
  state_t r_state;
  logic [HALL_W-1:0] r_last, w_code;
  logic signed [VEL_W-1:0] r_acc, w_acc_n, w_pub;
  logic r_fault, w_accept, w_legal, w_run_acc, w_fwd, w_rev, w_fault_ev, w_term;
  hall_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk(clk), .rst_n(rst_n), .i_hall(i_hall),
    .o_accepted_code(w_code), .o_accept_pulse(w_accept)
  );
  assign w_term     = r_win == CW'(WINDOW_CYCLES - 1);
  assign w_legal    = (w_code != HALL_000) && (w_code != HALL_111);
  assign w_run_acc  = w_accept && w_legal && (r_state == RUN);
  assign w_fwd      = w_run_acc && (w_code == hall_next(r_last));
  assign w_rev      = w_run_acc && (w_code == hall_prev(r_last));
  // A repeat of the last code (e.g. returning after an illegal code) is neither a step nor a fault
  assign w_fault_ev = w_accept && (!w_legal || (w_run_acc && w_code != r_last && !w_fwd && !w_rev));
  assign w_acc_n    = (w_fwd && r_acc != VMAX) ? r_acc + VEL_W'(1) :
                      (w_rev && r_acc != VMIN) ? r_acc - VEL_W'(1) : r_acc;
`ifdef VEL_AVG_EN
  logic signed [VEL_W-1:0] r_prev_acc;
  logic signed [VEL_W:0] w_sum;
  assign w_sum = {w_acc_n[VEL_W-1], w_acc_n} + {r_prev_acc[VEL_W-1], r_prev_acc};
  assign w_pub = w_sum[VEL_W:1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev_acc <= '0;
    else if (w_term) r_prev_acc <= w_acc_n;
  end
`else
  assign w_pub = w_acc_n;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win         <= '0;
      r_state       <= INIT;
      r_last        <= '0;
      r_acc         <= '0;
      r_fault       <= 1'b0;
      o_current_vel <= '0;
      o_vel_valid   <= 1'b0;
      o_dir         <= 1'b0;
      o_hall_fault  <= 1'b0;
    end else begin
      r_win       <= w_term ? '0 : r_win + 1'b1;
      o_vel_valid <= w_term;
      if (w_accept && w_legal) begin
        r_last  <= w_code;
        r_state <= RUN;
      end
      if (w_fwd) o_dir <= 1'b1;
      else if (w_rev) o_dir <= 1'b0;
      if (w_term) begin
        o_current_vel <= w_pub;
        o_hall_fault  <= r_fault | w_fault_ev;
        r_acc         <= '0;
        r_fault       <= 1'b0;
      end else begin
        r_acc   <= w_acc_n;
        r_fault <= r_fault | w_fault_ev;
      end
    end
  end
endmodule

// File: tb/tb_hall_velocity_meter.sv
// tb_hall_velocity_meter: random and directed hall stimulus against a step-counting model
module tb_hall_velocity_meter;
  localparam int S = 2;
  localparam int D = 4;
  int W[2] = '{100, 2000};
  int FWD[6] = '{1, 3, 2, 6, 4, 5};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] hall = 3'd1;
  logic signed [8:0] vel0, vel1;
  logic vv0, vv1, dir0, dir1, hf0, hf1;
  hall_velocity_meter #(.WINDOW_CYCLES(100), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .i_hall(hall),
    .o_current_vel(vel0), .o_vel_valid(vv0), .o_dir(dir0), .o_hall_fault(hf0)
  );
  hall_velocity_meter #(.WINDOW_CYCLES(2000), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_hall(hall),
    .o_current_vel(vel1), .o_vel_valid(vv1), .o_dir(dir1), .o_hall_fault(hf1)
  );
  always #5 clk = ~clk;
  int checks = 0, passes = 0, fails = 0;
  int k, acc_code, last, dir_e, pend_v, pend_c;
  int hist[$];
  int acc[2], flt[2], prv[2], ev[2], ef[2];
  bit strobe[2];
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int pos(input int c);
    for (int i = 0; i < 6; i++) if (FWD[i] == c) return i;
    return -1;
  endfunction
  function automatic int hv(input int j);
    return (j >= 1) ? hist[j-1] : 0;
  endfunction
  function automatic int pub(input int a, input int p);
`ifdef VEL_AVG_EN
    int s = a + p;
    return (s >= 0) ? s / 2 : -((1 - s) / 2);
`else
    return a;
`endif
  endfunction
  task automatic model_reset();
    k = 0; hist.delete(); acc_code = 0; last = 0; dir_e = 0; pend_v = 0; pend_c = 0;
    for (int i = 0; i < 2; i++) begin acc[i] = 0; flt[i] = 0; prv[i] = 0; ev[i] = 0; ef[i] = 0; end
  endtask
  task automatic do_reset(input int cyc);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_vel", vel0, 0);
    chk("rst_valid", vv0, 0);
    chk("rst_dir", dir0, 0);
    chk("rst_fault", hf0, 0);
    chk("rst_vel2", vel1, 0);
    chk("rst_valid2", vv1, 0);
    repeat (cyc) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask
  // One clock: drive hall, advance the model by one edge, check outputs just after the edge
  task automatic tick(input int h);
    int st, fl, x, run, d;
    hall = 3'(h);
    @(posedge clk);
    k++;
    hist.push_back(h);
    st = 0; fl = 0;
    if (pend_v != 0) begin
      if (pend_c == 0 || pend_c == 7) fl = 1;
      else if (last == 0) last = pend_c;
      else if (pend_c != last) begin
        d = (pos(pend_c) - pos(last) + 6) % 6;
        if (d == 1) st = 1;
        else if (d == 5) st = -1;
        else fl = 1;
        last = pend_c;
      end
    end
    if (st != 0) dir_e = (st > 0) ? 1 : 0;
    for (int i = 0; i < 2; i++) begin
      acc[i] = acc[i] + st;
      if (acc[i] > 255) acc[i] = 255;
      if (acc[i] < -255) acc[i] = -255;
      flt[i] = flt[i] | fl;
      strobe[i] = (k % W[i]) == 0;
      if (strobe[i]) begin
        ev[i] = pub(acc[i], prv[i]);
        prv[i] = acc[i];
        ef[i] = flt[i];
        acc[i] = 0;
        flt[i] = 0;
      end
    end
    x = hv(k - S);
    run = 1;
    for (int t = 1; t < D; t++) if (hv(k - S - t) != x) run = 0;
    pend_v = (run != 0 && x != acc_code) ? 1 : 0;
    if (pend_v != 0) begin pend_c = x; acc_code = x; end
    #1;
    chk("valid", vv0, strobe[0]);
    chk("valid2k", vv1, strobe[1]);
    if (strobe[0]) begin
      chk("vel", vel0, ev[0]);
      chk("fault", hf0, ef[0]);
      chk("dir", dir0, dir_e);
    end
    if (strobe[1]) begin
      chk("vel2k", vel1, ev[1]);
      chk("fault2k", hf1, ef[1]);
      chk("dir2k", dir1, dir_e);
    end
    @(negedge clk);
  endtask
  task automatic hold(input int h, input int n);
    repeat (n) tick(h);
  endtask
  initial begin
    int p, r;
    model_reset();
    do_reset(3);
    hold(1, 250);
    for (int i = 1; i <= 6; i++) hold(FWD[i % 6], 10);
    hold(1, 150);
    do_reset(2);
    hold(1, 10);
    for (int i = 5; i >= 1; i--) hold(FWD[i], 10);
    hold(3, 150);
    do_reset(2);
    hold(1, 20);
    hold(3, 3);
    hold(1, 10);
    hold(0, 10);
    hold(1, 250);
    do_reset(2);
    p = 0;
    hold(1, 10);
    while (k < 20100) begin
      p = (p + 1) % 6;
      hold(FWD[p], $urandom_range(5, 7));
    end
    for (int n = 0; n < 700; n++) begin
      p = (p + 5) % 6;
      hold(FWD[p], 6);
    end
    do_reset(3);
    hold(1, 20);
    for (int i = 1; i <= 7; i++) hold(FWD[i % 6], 8);
    hall = 3'd3;
    do_reset(4);
    hold(2, 10);
    hold(6, 150);
    do_reset(2);
    p = 0;
    hold(1, 10);
    repeat (300) begin
      r = $urandom_range(0, 9);
      if (r == 0) hold(($urandom_range(0, 1) != 0) ? 7 : 0, $urandom_range(1, 12));
      else if (r == 1) hold(FWD[$urandom_range(0, 5)], $urandom_range(1, 3));
      else if (r == 2) begin
        p = (p + $urandom_range(2, 3)) % 6;
        hold(FWD[p], $urandom_range(4, 15));
      end else begin
        p = (p + ((r > 5) ? 1 : 5)) % 6;
        hold(FWD[p], $urandom_range(4, 15));
      end
    end
    hold(FWD[p], 120);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
